// File: rtl/adventure_pkg.sv
// rtl/adventure_pkg.sv - room codes and direction bit indices for the adventure game
package adventure_pkg;

  typedef enum logic [2:0] {
    CAVE      = 3'd0,
    TUNNEL    = 3'd1,
    RIVER     = 3'd2,
    STASH     = 3'd3,
    DEN       = 3'd4,
    VICTORY   = 3'd5,
    GRAVEYARD = 3'd6
  } room_t;

  localparam int DIR_BITS = 4;

  // bit positions inside dir = {n,s,e,w}
  localparam int DIR_N = 3;
  localparam int DIR_S = 2;
  localparam int DIR_E = 1;
  localparam int DIR_W = 0;

endpackage

// File: rtl/dir_press.sv
// rtl/dir_press.sv - single-press detector: one-hot direction accepted only after all buttons released
module dir_press
  import adventure_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [DIR_BITS-1:0] dir,
  output logic                press_valid,
  output logic [DIR_BITS-1:0] press_dir
);

  logic [DIR_BITS-1:0] prev_dir;
  logic                one_hot;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_dir <= '0;
    else        prev_dir <= dir;
  end

  // x & (x-1) clears the lowest set bit; zero result with x != 0 means exactly one bit
  assign one_hot     = (dir != '0) && ((dir & (dir - {{(DIR_BITS-1){1'b0}}, 1'b1})) == '0);
  assign press_valid = one_hot && (prev_dir == '0);
  assign press_dir   = press_valid ? dir : '0;

endmodule

// File: rtl/adventure_rooms.sv
// rtl/adventure_rooms.sv - room-tracking FSM with sword-resolved dragon den and saturating move count
module adventure_rooms
  import adventure_pkg::*;
#(
  parameter int MOVE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n,
  input  logic              s,
  input  logic              e,
  input  logic              w,
  input  logic              v,
  output logic [2:0]        room,
  output logic              in_secret_sword_stash,
  output logic              win,
  output logic              dead,
  output logic [MOVE_W-1:0] moves
);

  room_t               room_q, room_d;
  logic [MOVE_W-1:0]   moves_q;
  logic                press_valid;
  logic [DIR_BITS-1:0] press_dir;
  logic                counted;

  dir_press u_dir_press (
    .clk         (clk),
    .reset       (reset),
    .dir         ({n, s, e, w}),
    .press_valid (press_valid),
    .press_dir   (press_dir)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) room_q <= CAVE;
    else        room_q <= room_d;
  end

  always_comb begin
    room_d = room_q;
    if (room_q == DEN) begin
      // den dwells one cycle; the sword flag at its closing edge decides the outcome
      room_d = v ? VICTORY : GRAVEYARD;
    end else if (press_valid) begin
      case (room_q)
        CAVE:    if (press_dir[DIR_E]) room_d = TUNNEL;
        TUNNEL: begin
          if (press_dir[DIR_S]) room_d = RIVER;
          if (press_dir[DIR_W]) room_d = CAVE;
        end
        RIVER: begin
          if (press_dir[DIR_N]) room_d = TUNNEL;
          if (press_dir[DIR_W]) room_d = STASH;
          if (press_dir[DIR_E]) room_d = DEN;
        end
        STASH:   if (press_dir[DIR_E]) room_d = RIVER;
        default: room_d = room_q;
      endcase
    end
  end

  assign counted = press_valid && (room_q != DEN) && (room_d != room_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          moves_q <= '0;
    else if (counted && (moves_q != '1)) moves_q <= moves_q + {{(MOVE_W-1){1'b0}}, 1'b1};
  end

  assign room                  = room_q;
  assign moves                 = moves_q;
  assign in_secret_sword_stash = (room_q == STASH);
  assign win                   = (room_q == VICTORY);
  assign dead                  = (room_q == GRAVEYARD);

endmodule

// File: tb/tb_adventure_rooms.sv
// tb/tb_adventure_rooms.sv - directed scoreboard bench for adventure_rooms (MOVE_W=8 and MOVE_W=2 copies)
module tb_adventure_rooms;
  import adventure_pkg::*;

  localparam logic [3:0] D_0 = 4'b0000;
  localparam logic [3:0] D_N = 4'b1000;
  localparam logic [3:0] D_S = 4'b0100;
  localparam logic [3:0] D_E = 4'b0010;
  localparam logic [3:0] D_W = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
  logic       v = 1'b0;
  logic [2:0] room, room2;
  logic       stash, win, dead, stash2, win2, dead2;
  logic [7:0] moves;
  logic [1:0] moves2;

  typedef struct {
    room_t room;
    int    mv;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  adventure_rooms #(.MOVE_W(8)) dut (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
    .room(room), .in_secret_sword_stash(stash), .win(win), .dead(dead), .moves(moves)
  );

  adventure_rooms #(.MOVE_W(2)) dut2 (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
    .room(room2), .in_secret_sword_stash(stash2), .win(win2), .dead(dead2), .moves(moves2)
  );

  // sword block: latches the stash indication, cleared only by reset
  always @(posedge clk or negedge reset) begin
    if (!reset)     v <= 1'b0;
    else if (stash) v <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_front();
    exp_t x;
    int   m2;
    x  = sbq.pop_front();
    m2 = (x.mv > 3) ? 3 : x.mv;
    chk({x.tag, ".room"},  {29'd0, room},   {29'd0, x.room});
    chk({x.tag, ".moves"}, {24'd0, moves},  x.mv);
    chk({x.tag, ".stash"}, {31'd0, stash},  {31'd0, (x.room == STASH)});
    chk({x.tag, ".win"},   {31'd0, win},    {31'd0, (x.room == VICTORY)});
    chk({x.tag, ".dead"},  {31'd0, dead},   {31'd0, (x.room == GRAVEYARD)});
    chk({x.tag, ".room2"}, {29'd0, room2},  {29'd0, x.room});
    chk({x.tag, ".moves2"},{30'd0, moves2}, m2);
  endtask

  task automatic step(input logic [3:0] d, input room_t r, input int mv, input string tag);
    {n, s, e, w} = d;
    sbq.push_back('{r, mv, tag});
    @(posedge clk);
    @(negedge clk);
    check_front();
  endtask

  task automatic do_reset(input logic [3:0] d, input string tag);
    {n, s, e, w} = d;
    reset = 1'b0;
    sbq.push_back('{CAVE, 0, tag});
    #1;
    check_front();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // power-on reset
    @(negedge clk);
    do_reset(D_0, "por");

    // held button gives a single move
    step(D_E, TUNNEL, 1, "hold1");
    for (int i = 0; i < 4; i++) step(D_E, TUNNEL, 1, "hold");
    step(D_0, TUNNEL, 1, "hold_rel");

    // sword path to victory
    do_reset(D_0, "rst_sword");
    step(D_E, TUNNEL, 1, "sw_e");   step(D_0, TUNNEL, 1, "sw_r1");
    step(D_S, RIVER, 2, "sw_s");    step(D_0, RIVER, 2, "sw_r2");
    step(D_W, STASH, 3, "sw_w");    step(D_0, STASH, 3, "sw_r3");
    step(D_E, RIVER, 4, "sw_e2");   step(D_0, RIVER, 4, "sw_r4");
    step(D_E, DEN, 5, "sw_den");
    step(D_0, VICTORY, 5, "sw_vic");
    step(D_W, VICTORY, 5, "sw_term");

    // reset in victory with e held across release
    do_reset(D_E, "rst_vic");
    step(D_E, TUNNEL, 1, "held_thru_rst");
    step(D_0, TUNNEL, 1, "held_rel");

    // no-sword death path
    do_reset(D_0, "rst_death");
    step(D_E, TUNNEL, 1, "dt_e");   step(D_0, TUNNEL, 1, "dt_r1");
    step(D_S, RIVER, 2, "dt_s");    step(D_0, RIVER, 2, "dt_r2");
    step(D_E, DEN, 3, "dt_den");
    step(D_0, GRAVEYARD, 3, "dt_grave");
    step(D_W, GRAVEYARD, 3, "dt_w");  step(D_0, GRAVEYARD, 3, "dt_r3");
    step(D_N, GRAVEYARD, 3, "dt_n");  step(D_0, GRAVEYARD, 3, "dt_r4");

    // simultaneous press in river
    do_reset(D_0, "rst_multi");
    step(D_E, TUNNEL, 1, "mb_e");   step(D_0, TUNNEL, 1, "mb_r1");
    step(D_S, RIVER, 2, "mb_s");    step(D_0, RIVER, 2, "mb_r2");
    step(D_N | D_E, RIVER, 2, "mb_ne");
    step(D_E, RIVER, 2, "mb_drop");
    step(D_0, RIVER, 2, "mb_r3");
    step(D_E, DEN, 3, "mb_den");
    step(D_0, GRAVEYARD, 3, "mb_grave");

    // counter saturation (MOVE_W=2 copy stops at 3)
    do_reset(D_0, "rst_sat");
    for (int i = 1; i <= 6; i++) begin
      if (i % 2 == 1) begin
        step(D_E, TUNNEL, i, "sat_e");
        step(D_0, TUNNEL, i, "sat_re");
      end else begin
        step(D_W, CAVE, i, "sat_w");
        step(D_0, CAVE, i, "sat_rw");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
